// File: rtl/pa_core_csr_ctrl.sv
// pa_core_csr_ctrl: CSR instruction / trap entry / MRET sequencer driving a single-port CSR file.
// Define PA_CORE_TRAP_VECTORED_EN to enable vectored interrupt trap targets.
module pa_core_csr_ctrl #(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int CSR_BUS_WIDTH  = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      csr_req_i,
  input  logic [1:0]                csr_op_i,
  input  logic [CSR_BUS_WIDTH-1:0]  csr_addr_i,
  input  logic [DATA_BUS_WIDTH-1:0] csr_src_i,
  output logic                      csr_ack_o,
  output logic [DATA_BUS_WIDTH-1:0] csr_rd_data_o,
  input  logic                      trap_req_i,
  input  logic [DATA_BUS_WIDTH-1:0] trap_cause_i,
  input  logic [DATA_BUS_WIDTH-1:0] trap_pc_i,
  input  logic [DATA_BUS_WIDTH-1:0] trap_val_i,
  input  logic                      mret_req_i,
  output logic                      busy_o,
  output logic                      redirect_vld_o,
  output logic [DATA_BUS_WIDTH-1:0] redirect_pc_o,
  output logic [CSR_BUS_WIDTH-1:0]  csr_raddr_o,
  input  logic [DATA_BUS_WIDTH-1:0] csr_rdata_i,
  output logic [CSR_BUS_WIDTH-1:0]  csr_waddr_o,
  output logic                      csr_waddr_vld_o,
  output logic [DATA_BUS_WIDTH-1:0] csr_wdata_o,
  input  logic [DATA_BUS_WIDTH-1:0] csr_mtvec_i,
  input  logic [DATA_BUS_WIDTH-1:0] csr_mepc_i,
  input  logic [DATA_BUS_WIDTH-1:0] csr_mstatus_i
);
  typedef enum logic [2:0] {
    IDLE, CSR_WR, TRAP_EPC, TRAP_CAUSE, TRAP_TVAL, TRAP_STAT, MRET_STAT, REDIRECT
  } state_t;
  localparam logic [DATA_BUS_WIDTH-1:0] LOW2 = DATA_BUS_WIDTH'(3);
  state_t                    state, state_nxt;
  logic [1:0]                op_q;
  logic [CSR_BUS_WIDTH-1:0]  addr_q;
  logic [DATA_BUS_WIDTH-1:0] src_q, old_q, cause_q, pc_q, val_q;
  logic                      trap_q;
  logic                      idle, trap_acc, mret_acc, csr_acc, csr_we;
  logic [DATA_BUS_WIDTH-1:0] csr_new, trap_stat, mret_stat, trap_base, trap_tgt;
  assign idle     = state == IDLE;
  assign trap_acc = idle && trap_req_i;
  assign mret_acc = idle && !trap_req_i && mret_req_i;
  assign csr_acc  = idle && !trap_req_i && !mret_req_i && csr_req_i;
  // op 00 is reserved and behaves as RW, so op_q[1] alone separates RW from RS/RC
  assign csr_new = op_q == 2'b10 ? old_q | src_q : op_q == 2'b11 ? old_q & ~src_q : src_q;
  assign csr_we  = !op_q[1] || src_q != '0;
  always_comb begin
    trap_stat        = csr_mstatus_i;
    trap_stat[7]     = csr_mstatus_i[3];
    trap_stat[3]     = 1'b0;
    trap_stat[12:11] = 2'b11;
    mret_stat        = csr_mstatus_i;
    mret_stat[3]     = csr_mstatus_i[7];
    mret_stat[7]     = 1'b1;
    mret_stat[12:11] = 2'b11;
  end
  assign trap_base = csr_mtvec_i & ~LOW2;
`ifdef PA_CORE_TRAP_VECTORED_EN
  assign trap_tgt = csr_mtvec_i[1:0] == 2'b01 && cause_q[DATA_BUS_WIDTH-1]
                  ? trap_base + {cause_q[DATA_BUS_WIDTH-3:0], 2'b00} : trap_base;
`else
  assign trap_tgt = trap_base;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q    <= '0;
      addr_q  <= '0;
      src_q   <= '0;
      old_q   <= '0;
      cause_q <= '0;
      pc_q    <= '0;
      val_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      if (csr_acc) begin
        op_q   <= csr_op_i;
        addr_q <= csr_addr_i;
        src_q  <= csr_src_i;
        old_q  <= csr_rdata_i;
      end
      if (trap_acc) begin
        cause_q <= trap_cause_i;
        pc_q    <= trap_pc_i & ~LOW2;
        val_q   <= trap_val_i;
        trap_q  <= 1'b1;
      end
      if (mret_acc) trap_q <= 1'b0;
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = trap_acc ? TRAP_EPC : mret_acc ? MRET_STAT : csr_acc ? CSR_WR : IDLE;
      CSR_WR:     state_nxt = IDLE;
      TRAP_EPC:   state_nxt = TRAP_CAUSE;
      TRAP_CAUSE: state_nxt = TRAP_TVAL;
      TRAP_TVAL:  state_nxt = TRAP_STAT;
      TRAP_STAT:  state_nxt = REDIRECT;
      MRET_STAT:  state_nxt = REDIRECT;
      REDIRECT:   state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end
  always_comb begin
    busy_o          = !idle;
    csr_raddr_o     = idle ? csr_addr_i : addr_q;
    csr_ack_o       = state == CSR_WR;
    csr_rd_data_o   = csr_ack_o ? old_q : '0;
    redirect_vld_o  = state == REDIRECT;
    redirect_pc_o   = !redirect_vld_o ? '0 : trap_q ? trap_tgt : csr_mepc_i;
    csr_waddr_vld_o = (state == CSR_WR && csr_we) || state == TRAP_EPC || state == TRAP_CAUSE ||
                      state == TRAP_TVAL || state == TRAP_STAT || state == MRET_STAT;
    csr_waddr_o     = state == CSR_WR     ? addr_q :
                      state == TRAP_EPC   ? CSR_BUS_WIDTH'(12'h341) :
                      state == TRAP_CAUSE ? CSR_BUS_WIDTH'(12'h342) :
                      state == TRAP_TVAL  ? CSR_BUS_WIDTH'(12'h343) :
                      state == TRAP_STAT || state == MRET_STAT ? CSR_BUS_WIDTH'(12'h300) : '0;
    csr_wdata_o     = state == CSR_WR     ? csr_new :
                      state == TRAP_EPC   ? pc_q :
                      state == TRAP_CAUSE ? cause_q :
                      state == TRAP_TVAL  ? val_q :
                      state == TRAP_STAT  ? trap_stat :
                      state == MRET_STAT  ? mret_stat : '0;
  end
endmodule

// File: doc/pa_core_csr_ctrl.md
# pa_core_csr_ctrl

CSR access and trap sequencer: the initiator side of the core's CSR register file. It turns CSR instructions (CSRRW/CSRRS/CSRRC), trap entry and MRET into ordered single-port read/write transactions on the CSR file. It also produces the PC redirect for traps and MRET. It sits between the execute stage and the CSR file.

## Interface
Parameters:
- DATA_BUS_WIDTH, 32, CSR data width
- CSR_BUS_WIDTH, 12, CSR address width

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- csr_req_i  in  1  CSR instruction request, single-cycle pulse
- csr_op_i  in  2  01=RW, 10=RS (set), 11=RC (clear); 00 reserved, treated as RW
- csr_addr_i  in  CSR_BUS_WIDTH  target CSR
- csr_src_i  in  DATA_BUS_WIDTH  rs1/zimm operand
- csr_ack_o  out  1  CSR instruction done, one-cycle pulse
- csr_rd_data_o  out  DATA_BUS_WIDTH  old CSR value, valid with csr_ack_o
- trap_req_i  in  1  trap entry request, pulse
- trap_cause_i, trap_pc_i, trap_val_i  in  DATA_BUS_WIDTH each  mcause, mepc and mtval values
- mret_req_i  in  1  MRET request, pulse
- busy_o  out  1  sequencer not idle
- redirect_vld_o  out  1  PC redirect, one-cycle pulse
- redirect_pc_o  out  DATA_BUS_WIDTH  redirect target
- csr_raddr_o  out  CSR_BUS_WIDTH  CSR file read address
- csr_rdata_i  in  DATA_BUS_WIDTH  CSR file read data (combinational)
- csr_waddr_o  out  CSR_BUS_WIDTH  CSR file write address
- csr_waddr_vld_o  out  1  CSR file write strobe
- csr_wdata_o  out  DATA_BUS_WIDTH  CSR file write data
- csr_mtvec_i, csr_mepc_i, csr_mstatus_i  in  DATA_BUS_WIDTH each  direct CSR views

## Operation
- FSM states: IDLE, CSR_WR, TRAP_EPC, TRAP_CAUSE, TRAP_TVAL, TRAP_STAT, MRET_STAT, REDIRECT.
- Requests are accepted only in IDLE (busy_o=0).
  - Requests while busy_o=1 are ignored; issuing them is a requester error.
  - All request inputs are captured on acceptance.
- Priority when requests coincide: trap > mret > csr. Lower-priority requests in that cycle are dropped.
- CSR instruction:
  - In IDLE: csr_raddr_o=csr_addr_i combinationally; capture old=csr_rdata_i; go to CSR_WR.
  - In CSR_WR, new value: RW gives src; RS gives old|src; RC gives old&~src.
  - Write strobe is suppressed for RS/RC when src==0.
  - csr_ack_o=1 and csr_rd_data_o=old; then return to IDLE.
- Trap, one CSR write per state:
  - TRAP_EPC: mepc(0x341) = trap_pc with bits[1:0] forced to 0.
  - TRAP_CAUSE: mcause(0x342) = cause.
  - TRAP_TVAL: mtval(0x343) = val.
  - TRAP_STAT: mstatus(0x300) = csr_mstatus_i with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=11.
  - Then REDIRECT.
- MRET:
  - MRET_STAT: mstatus = csr_mstatus_i with MIE[3]=MPIE[7], MPIE[7]=1, MPP=11.
  - Then REDIRECT with target csr_mepc_i.
- REDIRECT: redirect_vld_o=1 and redirect_pc_o=target; then IDLE.
  - Trap target: {csr_mtvec_i[31:2],2'b00}, subject to Configuration.
- Outside IDLE, csr_raddr_o holds the captured address.
- csr_waddr_vld_o is high in exactly the write states listed above, never elsewhere.

## Timing
- Reset values: state IDLE; csr_ack_o, csr_rd_data_o, busy_o, redirect_vld_o, redirect_pc_o, csr_waddr_o, csr_waddr_vld_o, csr_wdata_o all 0.
- Write outputs are registered-state decodes. A write lands in the CSR file on the edge ending its state.
- CSR instruction accepted at cycle T:
  - ack at T+1.
  - Write visible at T+2.
  - busy_o=1 at T+1 only.
- Trap accepted at T:
  - writes at T+1..T+4, in the order mepc, mcause, mtval, mstatus.
  - redirect at T+5.
  - IDLE at T+6.
- MRET accepted at T: mstatus write at T+1, redirect at T+2.
- REDIRECT samples csr_mtvec_i/csr_mepc_i after all sequence writes have landed.
- rst_i mid-sequence: next cycle is IDLE; no further writes, ack or redirect. Already-landed writes remain.

## Configuration
- PA_CORE_TRAP_VECTORED_EN defined:
  - If csr_mtvec_i[1:0]==01 and cause[31]==1 (interrupt), trap target = {mtvec[31:2],2'b00} + 4*cause[30:0] (mod 2^32).
  - Otherwise the target is the direct base.
- Undefined: target is always the direct base; mtvec[1:0] is ignored.

## Test plan
- CSRRW: mscratch=0x1234, op=RW, src=0xAAAA → ack at T+1, rd_data=0x1234; mscratch=0xAAAA.
- CSRRS with src=0 on mie=0x88 → rd_data=0x88, no csr_waddr_vld_o pulse.
- CSRRC: src=0x8 on mie=0x88 → mie=0x80.
- Trap: pc=0x102, cause=0xB, val=0x55, mstatus=0x8, mtvec=0x200 → writes mepc=0x100, mcause=0xB, mtval=0x55, mstatus=0x1880 on T+1..T+4; redirect 0x200 at T+5.
- Vectored, macro on: mtvec=0x201, cause=0x80000007 → redirect 0x21C. Macro off → 0x200.
- Simultaneous trap+csr_req → only the trap sequence runs, no ack.
- MRET with mstatus=0x80 → 0x1888, redirect=mepc.
- rst_i at T+2 of a trap → no further writes or redirect.
